rgb2yuv_arb: RTL and testbench



---
 rtl/rgb2yuv_arb.sv | 241 ++++++++++++++++++++++++
 tb/tb_rgb2yuv_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2yuv_arb.sv
// Two-channel RGB->YUV scheduler: round-robin arbitration over one shared,
// free-running converter, tag pipeline aligned with the converter latency,
// and per-channel FWFT output FIFOs protected by credit counters.

// Fixed-point RGB->YUV converter, C_DLY cycles from input to output, no stall.
module rgb2yuv #(
    parameter int C_BPC = 8,
    parameter int C_DLY = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [C_BPC-1:0] r,
    input  logic [C_BPC-1:0] g,
    input  logic [C_BPC-1:0] b,
    output logic [C_BPC-1:0] y,
    output logic [C_BPC-1:0] u,
    output logic [C_BPC-1:0] v
);
    localparam int SW = C_BPC + 8;

    logic [SW-1:0]      r_e, g_e, b_e;
    logic [SW-1:0]      y_sum, u_sum, v_sum;
    logic [3*C_BPC-1:0] stage_q [1:C_DLY];
    logic               unused_frac;

    assign r_e = SW'(r);
    assign g_e = SW'(g);
    assign b_e = SW'(b);

    // Weighted sums; the mid-scale bias keeps U and V non-negative, so
    // wrap-around arithmetic in SW bits yields the exact result.
    always_comb begin
        y_sum = SW'(77) * r_e + SW'(150) * g_e + SW'(29) * b_e;
        u_sum = (SW'(128) << C_BPC) - SW'(43) * r_e - SW'(85) * g_e + SW'(128) * b_e;
        v_sum = (SW'(128) << C_BPC) + SW'(128) * r_e - SW'(107) * g_e - SW'(21) * b_e;
    end

    // The fractional byte is dropped by the truncating divide.
    assign unused_frac = ^{y_sum[7:0], u_sum[7:0], v_sum[7:0]};

    // Stage 1 truncates the sums; later stages only delay to reach C_DLY.
    // NOTE: clocked state uses <= so every stage samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 1; i <= C_DLY; i++) stage_q[i] <= '0;
        end else begin
            stage_q[1] <= {y_sum[SW-1:8], u_sum[SW-1:8], v_sum[SW-1:8]};
            for (int i = 2; i <= C_DLY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign {y, u, v} = stage_q[C_DLY];
endmodule

// First-word-fall-through FIFO with wrapping binary pointers.
module rgb2yuv_arb_fifo #(
    parameter int C_W     = 25,
    parameter int C_DEPTH = 8
) (
    input  logic           clk_in,
    input  logic           rst,
    input  logic           push,
    input  logic [C_W-1:0] wdata,
    input  logic           pop,
    output logic           valid,
    output logic [C_W-1:0] rdata
);
    localparam int AW = $clog2(C_DEPTH);

    logic [C_W-1:0] mem [C_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           full;

    // Storage write.
    // NOTE: the array has no reset; the pointers define what is valid and
    // rdata is forced to zero while empty.
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign valid = (count != '0);
    assign full  = (count == (AW+1)'(C_DEPTH));
    assign rdata = valid ? mem[rd_ptr] : '0;

    // Credits upstream make this unreachable; a hit means credit accounting broke.
    assert property (@(posedge clk_in) disable iff (rst) !(push && full))
        else $error("rgb2yuv_arb_fifo: push into full FIFO");
endmodule

// Top: arbitration, credits, issue register, tag pipeline, output FIFOs.
module rgb2yuv_arb #(
    parameter int C_BPC        = 8,
    parameter int C_DLY        = 2,
    parameter int C_FIFO_DEPTH = 8
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             S0_VALID_I,
    output logic             S0_READY_O,
    input  logic [C_BPC-1:0] S0_R_I,
    input  logic [C_BPC-1:0] S0_G_I,
    input  logic [C_BPC-1:0] S0_B_I,
    input  logic             S0_LAST_I,
    input  logic             S1_VALID_I,
    output logic             S1_READY_O,
    input  logic [C_BPC-1:0] S1_R_I,
    input  logic [C_BPC-1:0] S1_G_I,
    input  logic [C_BPC-1:0] S1_B_I,
    input  logic             S1_LAST_I,
    output logic             M0_VALID_O,
    input  logic             M0_READY_I,
    output logic [C_BPC-1:0] M0_Y_O,
    output logic [C_BPC-1:0] M0_U_O,
    output logic [C_BPC-1:0] M0_V_O,
    output logic             M0_LAST_O,
    output logic             M1_VALID_O,
    input  logic             M1_READY_I,
    output logic [C_BPC-1:0] M1_Y_O,
    output logic [C_BPC-1:0] M1_U_O,
    output logic [C_BPC-1:0] M1_V_O,
    output logic             M1_LAST_O
);
    localparam int CW = $clog2(C_FIFO_DEPTH) + 1;
    localparam int DW = 3 * C_BPC + 1;

    typedef struct packed {
        logic v;
        logic ch;
        logic last;
    } tag_t;

    logic [1:0]       elig, gnt, m_ready, m_valid, pop, push;
    logic [CW-1:0]    cnt [2];
    logic             rr;
    logic [C_BPC-1:0] r_q, g_q, b_q, conv_y, conv_u, conv_v;
    tag_t             tag_q [0:C_DLY];
    tag_t             tag_out;
    logic [DW-1:0]    rdata [2];

    // A channel may be granted only if its FIFO has a free credit.
    assign elig[0] = !RST_I && S0_VALID_I && (cnt[0] < CW'(C_FIFO_DEPTH));
    assign elig[1] = !RST_I && S1_VALID_I && (cnt[1] < CW'(C_FIFO_DEPTH));

    // Single grant per cycle; rr breaks ties only.
    // NOTE: gnt gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = elig;
        if (&elig) gnt = rr ? 2'b10 : 2'b01;
    end

    assign S0_READY_O = gnt[0];
    assign S1_READY_O = gnt[1];
    assign m_ready    = {M1_READY_I, M0_READY_I};
    assign pop        = m_valid & m_ready;

    // Credit counters (granted but not yet popped) and the tie-break pointer.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            cnt[0] <= '0;
            cnt[1] <= '0;
            rr     <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                case ({gnt[n], pop[n]})
                    2'b10:   cnt[n] <= cnt[n] + 1'b1;
                    2'b01:   cnt[n] <= cnt[n] - 1'b1;
                    default: ;
                endcase
            end
            if (&elig) rr <= ~rr;
        end
    end

    // Issue register holds RGB when idle; the tag pipeline qualifies each slot.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
            for (int i = 0; i <= C_DLY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{v: |gnt, ch: gnt[1], last: (gnt[1] ? S1_LAST_I : S0_LAST_I)};
            for (int i = 1; i <= C_DLY; i++) tag_q[i] <= tag_q[i-1];
            if (|gnt) begin
                r_q <= gnt[1] ? S1_R_I : S0_R_I;
                g_q <= gnt[1] ? S1_G_I : S0_G_I;
                b_q <= gnt[1] ? S1_B_I : S0_B_I;
            end
        end
    end

    rgb2yuv #(.C_BPC(C_BPC), .C_DLY(C_DLY)) u_conv (
        .clk_in (CLK_I),
        .rst    (RST_I),
        .r      (r_q),
        .g      (g_q),
        .b      (b_q),
        .y      (conv_y),
        .u      (conv_u),
        .v      (conv_v)
    );

    assign tag_out = tag_q[C_DLY];
    assign push[0] = tag_out.v && !tag_out.ch;
    assign push[1] = tag_out.v && tag_out.ch;

    for (genvar n = 0; n < 2; n++) begin : g_fifo
        rgb2yuv_arb_fifo #(.C_W(DW), .C_DEPTH(C_FIFO_DEPTH)) u_fifo (
            .clk_in (CLK_I),
            .rst    (RST_I),
            .push   (push[n]),
            .wdata  ({conv_y, conv_u, conv_v, tag_out.last}),
            .pop    (pop[n]),
            .valid  (m_valid[n]),
            .rdata  (rdata[n])
        );
    end

    assign M0_VALID_O = m_valid[0];
    assign M1_VALID_O = m_valid[1];
    assign {M0_Y_O, M0_U_O, M0_V_O, M0_LAST_O} = rdata[0];
    assign {M1_Y_O, M1_U_O, M1_V_O, M1_LAST_O} = rdata[1];
endmodule

// File: tb/tb_rgb2yuv_arb.sv
// Directed bench for rgb2yuv_arb: reset state, hand-computed conversions,
// contention, backpressure and credit release, reset mid-stream, random soak.
module tb_rgb2yuv_arb;
    logic       clk_in = 1'b0;
    logic       rst;
    logic       s0_valid, s0_ready, s0_last, s1_valid, s1_ready, s1_last;
    logic [7:0] s0_r, s0_g, s0_b, s1_r, s1_g, s1_b;
    logic       m0_valid, m0_ready, m0_last, m1_valid, m1_ready, m1_last;
    logic [7:0] m0_y, m0_u, m0_v, m1_y, m1_u, m1_v;

    int checks = 0;
    int errors = 0;
    int sent0 = 0, sent1 = 0, recv0 = 0, recv1 = 0;
    int s1_start, goal0, goal1, cyc;
    bit h0, h1, v0, v1, r0, r1;

    always #5 clk_in = ~clk_in;

    rgb2yuv_arb #(.C_BPC(8), .C_DLY(2), .C_FIFO_DEPTH(8)) dut (
        .CLK_I(clk_in), .RST_I(rst),
        .S0_VALID_I(s0_valid), .S0_READY_O(s0_ready),
        .S0_R_I(s0_r), .S0_G_I(s0_g), .S0_B_I(s0_b), .S0_LAST_I(s0_last),
        .S1_VALID_I(s1_valid), .S1_READY_O(s1_ready),
        .S1_R_I(s1_r), .S1_G_I(s1_g), .S1_B_I(s1_b), .S1_LAST_I(s1_last),
        .M0_VALID_O(m0_valid), .M0_READY_I(m0_ready),
        .M0_Y_O(m0_y), .M0_U_O(m0_u), .M0_V_O(m0_v), .M0_LAST_O(m0_last),
        .M1_VALID_O(m1_valid), .M1_READY_I(m1_ready),
        .M1_Y_O(m1_y), .M1_U_O(m1_u), .M1_V_O(m1_v), .M1_LAST_O(m1_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Pixel i of channel ch in the streamed phases.
    function automatic logic [23:0] pix(input int ch, input int i);
        logic [7:0] r, g, b;
        r = 8'(i * 7 + ch * 31 + 3);
        g = 8'(i * 13 + ch * 77 + 5);
        b = 8'(i * 29 + ch * 101);
        return {r, g, b};
    endfunction

    // Reference conversion: integer arithmetic straight from the formulas.
    function automatic logic [24:0] ref_out(input logic [23:0] rgb, input bit last);
        int r, g, b, y, u, v;
        r = int'(rgb[23:16]);
        g = int'(rgb[15:8]);
        b = int'(rgb[7:0]);
        y = (77 * r + 150 * g + 29 * b) / 256;
        u = (32768 - 43 * r - 85 * g + 128 * b) / 256;
        v = (32768 + 128 * r - 107 * g - 21 * b) / 256;
        return {8'(y), 8'(u), 8'(v), last};
    endfunction

    // One cycle of streaming: drive model pixels, observe handshakes, check pops.
    task automatic cycle(input bit cv0, input bit cv1, input bit cr0, input bit cr1,
                         output bit hs0, output bit hs1);
        s0_valid = cv0;
        {s0_r, s0_g, s0_b} = pix(0, sent0);
        s0_last = (sent0 % 5 == 4);
        s1_valid = cv1;
        {s1_r, s1_g, s1_b} = pix(1, sent1);
        s1_last = (sent1 % 5 == 4);
        m0_ready = cr0;
        m1_ready = cr1;
        #1;
        hs0 = s0_ready && cv0;
        hs1 = s1_ready && cv1;
        if (!cv0) check("rdy_novalid0", 32'(s0_ready), 32'(0));
        if (!cv1) check("rdy_novalid1", 32'(s1_ready), 32'(0));
        if (m0_valid && cr0) begin
            check("m0_pix", 32'({m0_y, m0_u, m0_v, m0_last}),
                  32'(ref_out(pix(0, recv0), recv0 % 5 == 4)));
            recv0++;
        end
        if (m1_valid && cr1) begin
            check("m1_pix", 32'({m1_y, m1_u, m1_v, m1_last}),
                  32'(ref_out(pix(1, recv1), recv1 % 5 == 4)));
            recv1++;
        end
        tick();
        if (hs0) sent0++;
        if (hs1) sent1++;
    endtask

    task automatic drain(input string tag);
        bit d0, d1;
        for (int c = 0; c < 40 && (recv0 < sent0 || recv1 < sent1); c++)
            cycle(1'b0, 1'b0, 1'b1, 1'b1, d0, d1);
        check({tag, "_drain0"}, 32'(recv0), 32'(sent0));
        check({tag, "_drain1"}, 32'(recv1), 32'(sent1));
    endtask

    initial begin
        rst = 1'b1;
        s0_valid = 1'b1; s0_r = '0; s0_g = '0; s0_b = '0; s0_last = 1'b0;
        s1_valid = 1'b0; s1_r = '0; s1_g = '0; s1_b = '0; s1_last = 1'b0;
        m0_ready = 1'b0; m1_ready = 1'b0;

        // Reset state: READY gated by reset, outputs empty and zero.
        repeat (3) tick();
        check("rst_rdy0", 32'(s0_ready), 32'(0));
        check("rst_vld0", 32'(m0_valid), 32'(0));
        check("rst_vld1", 32'(m1_valid), 32'(0));
        check("rst_dat0", 32'({m0_y, m0_u, m0_v, m0_last}), 32'(0));
        check("rst_dat1", 32'({m1_y, m1_u, m1_v, m1_last}), 32'(0));
        rst = 1'b0;
        s0_valid = 1'b0;
        tick();

        // (255,0,0) -> 76/85/255, visible three edges after the handshake edge.
        s0_valid = 1'b1; s0_r = 8'd255; s0_g = 8'd0; s0_b = 8'd0; s0_last = 1'b1;
        #1;
        check("a_rdy", 32'(s0_ready), 32'(1));
        tick();
        s0_valid = 1'b0;
        check("a_lat0", 32'(m0_valid), 32'(0));
        tick();
        check("a_lat1", 32'(m0_valid), 32'(0));
        tick();
        check("a_lat2", 32'(m0_valid), 32'(0));
        tick();
        check("a_vld", 32'(m0_valid), 32'(1));
        check("a_pix", 32'({m0_y, m0_u, m0_v, m0_last}), 32'({8'd76, 8'd85, 8'd255, 1'b1}));
        m0_ready = 1'b1;
        tick();
        check("a_pop", 32'(m0_valid), 32'(0));

        // Gray and white back to back, order and LAST preserved.
        m0_ready = 1'b0;
        s0_valid = 1'b1; s0_r = 8'd128; s0_g = 8'd128; s0_b = 8'd128; s0_last = 1'b0;
        #1;
        check("b_rdy", 32'(s0_ready), 32'(1));
        tick();
        s0_r = 8'd255; s0_g = 8'd255; s0_b = 8'd255; s0_last = 1'b1;
        #1;
        check("c_rdy", 32'(s0_ready), 32'(1));
        tick();
        s0_valid = 1'b0;
        repeat (3) tick();
        check("b_pix", 32'({m0_y, m0_u, m0_v, m0_last}), 32'({8'd128, 8'd128, 8'd128, 1'b0}));
        m0_ready = 1'b1;
        tick();
        check("c_pix", 32'({m0_y, m0_u, m0_v, m0_last}), 32'({8'd255, 8'd128, 8'd128, 1'b1}));
        tick();
        check("c_pop", 32'(m0_valid), 32'(0));

        // Contention: grants alternate starting with channel 0.
        for (int c = 0; c < 20; c++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, h0, h1);
            check("ctn_g0", 32'(h0), 32'(c % 2 == 0));
            check("ctn_g1", 32'(h1), 32'(c % 2 == 1));
        end
        drain("ctn");
        check("ctn_cnt0", 32'(sent0), 32'(10));
        check("ctn_cnt1", 32'(sent1), 32'(10));

        // Backpressure on M1: S1 takes exactly 8, then S0 runs every cycle.
        s1_start = sent1;
        for (int c = 0; c < 30; c++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, h0, h1);
            check("bp_g0", 32'(h0), 32'((c < 16) ? (c % 2 == 0) : 1'b1));
            check("bp_g1", 32'(h1), 32'((c < 16) && (c % 2 == 1)));
        end
        check("bp_accepts", 32'(sent1 - s1_start), 32'(8));
        check("bp_held", 32'(m1_valid), 32'(1));

        // Release: the first pop re-enables S1 in the following cycle.
        for (int c = 0; c < 12; c++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, h0, h1);
            check("rel_g1", 32'(h1), 32'(c != 0));
        end
        drain("rel");

        // Reset mid-stream: 7 accepted, 4 buffered and 3 in flight, all dropped.
        m0_ready = 1'b0; m1_ready = 1'b0; s1_valid = 1'b0;
        s0_valid = 1'b1; s0_r = 8'd10; s0_g = 8'd20; s0_b = 8'd30; s0_last = 1'b0;
        for (int c = 0; c < 7; c++) begin
            #1;
            check("pre_rst_rdy", 32'(s0_ready), 32'(1));
            tick();
        end
        check("pre_rst_vld", 32'(m0_valid), 32'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", 32'(s0_ready), 32'(0));
        tick();
        rst = 1'b0;
        s0_valid = 1'b0;
        check("post_rst_vld", 32'(m0_valid), 32'(0));
        check("post_rst_dat", 32'({m0_y, m0_u, m0_v, m0_last}), 32'(0));
        m0_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("no_stale", 32'(m0_valid), 32'(0));
        end
        m0_ready = 1'b0;
        s0_valid = 1'b1; s0_r = 8'd0; s0_g = 8'd0; s0_b = 8'd255; s0_last = 1'b0;
        #1;
        check("d_rdy", 32'(s0_ready), 32'(1));
        tick();
        s0_valid = 1'b0;
        repeat (3) tick();
        check("d_vld", 32'(m0_valid), 32'(1));
        check("d_pix", 32'({m0_y, m0_u, m0_v, m0_last}), 32'({8'd28, 8'd255, 8'd107, 1'b0}));
        m0_ready = 1'b1;
        tick();
        check("d_pop", 32'(m0_valid), 32'(0));

        // Random soak: 10k pixels per channel, random VALID/READY, lines of 5.
        goal0 = sent0 + 10000;
        goal1 = sent1 + 10000;
        cyc = 0;
        while ((sent0 < goal0 || sent1 < goal1) && cyc < 60000) begin
            v0 = (sent0 < goal0) && ($urandom_range(3) != 0);
            v1 = (sent1 < goal1) && ($urandom_range(3) != 0);
            r0 = ($urandom_range(2) != 0);
            r1 = ($urandom_range(2) != 0);
            cycle(v0, v1, r0, r1, h0, h1);
            check("one_grant", 32'(h0 & h1), 32'(0));
            cyc++;
        end
        check("soak_done", 32'(cyc < 60000), 32'(1));
        drain("soak");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
